// File: rtl/jpeg_collect_pkg.sv
// Shared types and widths for the JPEG result collector.
package jpeg_collect_pkg;

    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OVF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/collect_fifo.sv
// Synchronous FIFO with a combinational head; pops take priority so a full
// FIFO can accept a push at the same edge it is popped.
module collect_fifo #(
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    assign full_c  = (cnt_q == LVL_W'(DEPTH));
    assign empty_c = (cnt_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign level_o = cnt_q;
    assign do_pop  = pop_i && !empty_c;
    assign do_push = push_i && (!full_c || do_pop);

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/jpeg_result_collector.sv
// Buffers JPEG IP result words and drains them as framed memory writes.
// Optional saturating drop counter: JPEG_COLLECT_OVF_CNT_EN.
module jpeg_result_collector
    import jpeg_collect_pkg::*;
#(
    parameter  int unsigned       DEPTH       = 8,
    parameter  int unsigned       FRAME_WORDS = 64,
    parameter  logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    localparam int unsigned       LVL_W       = $clog2(DEPTH) + 1,
    localparam int unsigned       WC_W        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 mem_busy,
    output logic                 mem_ena,
    output logic                 mem_rw,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 frame_done,
    output logic                 ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    output logic [LVL_W-1:0]     fifo_level
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              mem_ena_q, mem_ena_d, frame_done_q, frame_done_d, ovf_q;
    logic              pop_c, bypass_c, drop_c;
    logic [DATA_W-1:0] fifo_head_c;
    logic              fifo_full_c, fifo_empty_c;

    collect_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && !bypass_c),
        .pop_i   (pop_c),
        .wdata_i (in_data),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .level_o (fifo_level)
    );

    // A word is lost only when the FIFO is full and nothing leaves it this edge.
    assign drop_c = in_valid && fifo_full_c && !pop_c;

    // Drain FSM: next state, write-slot loading and address/frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wc_d         = wc_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        pop_c        = 1'b0;
        bypass_c     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (!fifo_empty_c) begin
                    pop_c      = 1'b1;
                    state_d    = ST_WRITE;
                    mem_addr_d = addr_q;
                    mem_data_d = fifo_head_c;
                end
            end
            ST_WRITE: begin
                if (!mem_busy) begin
                    if (wc_q == WC_W'(FRAME_WORDS - 1)) begin
                        state_d = ST_DONE;
                        addr_d  = BASE_ADDR;
                        wc_d    = '0;
                    end else begin
                        addr_d     = addr_q + ADDR_W'(1);
                        wc_d       = wc_q + WC_W'(1);
                        mem_addr_d = addr_q + ADDR_W'(1);
                        if (!fifo_empty_c) begin
                            pop_c      = 1'b1;
                            mem_data_d = fifo_head_c;
                        end else if (in_valid) begin
                            // Empty FIFO: a word arriving now goes straight into the slot.
                            bypass_c   = 1'b1;
                            mem_data_d = in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mem_ena_d    = (state_d == ST_WRITE);
        frame_done_d = (state_d == ST_DONE);
    end

    // State and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= BASE_ADDR;
            wc_q         <= '0;
            mem_addr_q   <= BASE_ADDR;
            mem_data_q   <= '0;
            mem_ena_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wc_q         <= wc_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_ena_q    <= mem_ena_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_q | drop_c;
        end
    end

    assign mem_ena    = mem_ena_q;
    assign mem_rw     = mem_ena_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;

`ifdef JPEG_COLLECT_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // Saturating count of dropped words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else if (drop_c && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_jpeg_result_collector.sv
// Randomised and directed bench for jpeg_result_collector with a queue-based model.
module tb_jpeg_result_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = 4;
    localparam logic [19:0] BASE  = 20'hFFFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        mem_busy = 1'b0;
    logic        mem_ena, mem_rw, frame_done, ovf;
    logic [19:0] mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  ovf_cnt;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jpeg_result_collector #(.DEPTH(DEPTH), .FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .mem_busy   (mem_busy),
        .mem_ena    (mem_ena),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .frame_done (frame_done),
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted, not-yet-completed word in order; the front one is
    // in the write slot while a write is active.
    logic [31:0] q[$];
    bit          m_act = 1'b0;
    bit          m_dn  = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_cnt = 0;
    int          m_wc  = 0;
    logic [19:0] m_addr = BASE;
    logic [31:0] log_data[$];
    logic [19:0] log_addr[$];
    int          done_seen = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_act = 1'b0; m_dn = 1'b0; m_ovf = 1'b0;
            m_cnt = 0; m_wc = 0; m_addr = BASE;
        end else begin
            int  in_fifo;
            bit  comp, fend, leaves, acc, was_act, was_dn;
            in_fifo = q.size() - (m_act ? 1 : 0);
            comp    = m_act && !mem_busy;
            fend    = comp && (m_wc == FW - 1);
            // A FIFO slot frees whenever the write slot takes a new word this edge.
            leaves  = (in_fifo > 0) && (!m_act || (comp && !fend));
            acc     = in_valid && ((in_fifo < DEPTH) || leaves);
            was_act = m_act;
            was_dn  = m_dn;
            if (mem_ena && !mem_busy) begin
                log_data.push_back(mem_data);
                log_addr.push_back(mem_addr);
            end
            if (frame_done) done_seen++;
            if (comp) begin
                void'(q.pop_front());
                if (fend) begin
                    m_wc = 0; m_addr = BASE;
                end else begin
                    m_wc++; m_addr = m_addr + 20'd1;
                end
            end
            if (acc) q.push_back(in_data);
            else if (in_valid) begin
                m_ovf = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            m_dn = 1'b0;
            if (was_dn || !was_act) m_act = (in_fifo > 0);
            else if (fend) begin m_act = 1'b0; m_dn = 1'b1; end
            else if (comp) m_act = (q.size() > 0);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [7:0] exp_cnt;
`ifdef JPEG_COLLECT_OVF_CNT_EN
        exp_cnt = 8'(m_cnt);
`else
        exp_cnt = 8'd0;
`endif
        chk("mem_ena", 32'(mem_ena), 32'(m_act));
        chk("mem_rw", 32'(mem_rw), 32'(m_act));
        chk("frame_done", 32'(frame_done), 32'(m_dn));
        chk("fifo_level", 32'(fifo_level), 32'(q.size() - int'(m_act)));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
        if (m_act && q.size() > 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_data", mem_data, q[0]);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic b);
        in_valid = v; in_data = d; mem_busy = b;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; mem_busy = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;
        log_data.delete(); log_addr.delete(); done_seen = 0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [7:0] ovf_exp;
        int         thr;
`ifdef JPEG_COLLECT_OVF_CNT_EN
        ovf_exp = 8'd1;
`else
        ovf_exp = 8'd0;
`endif
        // Reset values.
        do_reset();
        chk("rst_ena", 32'(mem_ena), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(BASE));
        chk("rst_data", mem_data, 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);

        // Single word latency.
        cyc(1'b1, 32'hDEADBEEF, 1'b0);
        chk("single_ena_n", 32'(mem_ena), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("single_ena_n1", 32'(mem_ena), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'(BASE));
        chk("single_data", mem_data, 32'hDEADBEEF);
        cyc(1'b0, 32'h0, 1'b0);
        chk("single_ena_n2", 32'(mem_ena), 32'd0);
        chk("single_writes", 32'(log_data.size()), 32'd1);

        // Stall ordering; the address wraps through 2^20 inside the frame.
        do_reset();
        cyc(1'b1, 32'h1, 1'b1);
        cyc(1'b1, 32'h2, 1'b1);
        cyc(1'b1, 32'h3, 1'b1);
        chk("stall_data", mem_data, 32'h1);
        chk("stall_addr", 32'(mem_addr), 32'(BASE));
        cyc(1'b1, 32'h4, 1'b0);
        idle(8);
        chk("stall_writes", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("stall_order", log_data[i], 32'(i + 1));
            chk("stall_waddr", 32'(log_addr[i]), 32'(20'(BASE + 20'(i))));
        end
        chk("stall_frame", 32'(done_seen), 32'd1);

        // Frame wrap: fifth word restarts at BASE.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'(100 + i), 1'b0);
        idle(10);
        chk("frame_writes", 32'(log_data.size()), 32'd6);
        chk("frame_pulses", 32'(done_seen), 32'd1);
        if (log_addr.size() >= 6) begin
            chk("frame_addr3", 32'(log_addr[3]), 32'h00001);
            chk("frame_addr4", 32'(log_addr[4]), 32'(BASE));
            chk("frame_data4", log_data[4], 32'd104);
        end

        // Overflow: one word in the write slot, eight buffered, one dropped.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(200 + i), 1'b1);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(ovf_cnt), 32'(ovf_exp));
        idle(16);
        chk("ovf_writes", 32'(log_data.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_data.size(); i++)
            chk("ovf_order", log_data[i], 32'(200 + i));

        // Full FIFO, push at the same edge as a completing write.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'(300 + i), 1'b1);
        chk("full_level", 32'(fifo_level), 32'd8);
        cyc(1'b1, 32'd399, 1'b0);
        chk("simul_level", 32'(fifo_level), 32'd8);
        chk("simul_ovf", 32'(ovf), 32'd0);
        idle(16);
        chk("simul_writes", 32'(log_data.size()), 32'd10);
        if (log_data.size() >= 10) chk("simul_last", log_data[9], 32'd399);

        // Random traffic with alternating stall pressure and occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            thr = ((i / 300) % 2 == 1) ? 75 : 20;
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc(1'($urandom_range(0, 99) < 65), $urandom,
                1'($urandom_range(0, 99) < thr));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
